// File: rtl/spi_inject_pkg.sv
// Shared types and constants for the SPI stimulus injector: FSM encoding,
// control/status bit positions and the tag-to-length helper.
package spi_inject_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESENT = 3'd1,
        ST_WAIT    = 3'd2
    } state_t;

    // Control word bits (write to address 0)
    localparam int CSR_ENABLE       = 0;
    localparam int CSR_FLUSH        = 1;
    localparam int CSR_CLR_UNDERRUN = 2;

    // Status word field offsets (read from address 0)
    localparam int STAT_WR_PTR   = 0;
    localparam int STAT_RD_PTR   = 8;
    localparam int STAT_COUNT    = 16;
    localparam int STAT_ENABLE   = 24;
    localparam int STAT_UNDERRUN = 25;
    localparam int STAT_EMPTY    = 26;
    localparam int STAT_FULL     = 27;
    localparam int STAT_STATE    = 28;

    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;
    localparam int         MAX_PAYLOAD       = 7;

    // Tag byte carries the payload length; anything beyond the word size clamps.
    function automatic logic [2:0] payload_len(input logic [7:0] tag);
        return (tag > 8'(MAX_PAYLOAD)) ? 3'(MAX_PAYLOAD) : tag[2:0];
    endfunction

endpackage

// File: rtl/spi_buffer_avalon_injector_if.sv
// Avalon-MM slave bus between the HPS bridge and the stimulus injector.
interface spi_buffer_avalon_injector_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/edge_event_sync.sv
// Synchronises an asynchronous level and flags a glitch-filtered rising edge:
// the input must be seen low, then high on two consecutive samples.
module edge_event_sync (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic [2:0] history;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) history <= 3'b111;
        else       history <= {history[1:0], level};
    end

    // The oldest history bit is kept for register compatibility with the
    // capture debugger but is masked out of the 0-1-1 pattern.
    assign pulse = (({history, level} & 4'b0111) == 4'b0011);

endmodule

// File: rtl/spi_buffer_avalon_injector.sv
// Avalon-MM ring of 64-bit stimulus words replayed byte by byte into the SPI
// transmit buffer; byte0 of each word is the payload length, byte1 goes first.
module spi_buffer_avalon_injector
    import spi_inject_pkg::*;
#(
    parameter int         ADDR_W    = 6,
    parameter int         DATA_W    = 64,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    spi_buffer_avalon_injector_if.slave   avalon,
    output logic [7:0]                    io_TX_Buffer,
    output logic                          io_TX_BufferLoad,
    input  logic                          io_TX_BufferConsumed,
    output logic                          io_TX_Underrun
);

    localparam int RING_DEPTH = (1 << ADDR_W) - 1;

    typedef logic [ADDR_W-1:0] ptr_t;

    // Slot 0 is the CSR, so ring pointers cycle through 1..RING_DEPTH only.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(RING_DEPTH)) ? ptr_t'(1) : p + ptr_t'(1);
    endfunction

    logic [DATA_W-1:0] ring [1:RING_DEPTH];

    ptr_t              wr_ptr;
    ptr_t              rd_ptr;
    ptr_t              count;
    logic              enable;
    logic              underrun;
    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] word;
    logic [2:0]        byte_idx;
    logic [2:0]        word_len;
    logic [7:0]        tx_buffer;
    logic              tx_load;
    logic              consumed_event;

    logic              csr_write;
    logic              ring_write;
    logic              flush;
    logic              push;
    logic              empty;
    logic              full;
    logic              fetch;
    logic              present;
    logic              advance;
    logic              pop;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] read_word;

    edge_event_sync u_consumed_sync (
        .clock (clock),
        .reset (reset),
        .level (io_TX_BufferConsumed),
        .pulse (consumed_event)
    );

    assign csr_write  = avalon.write && (avalon.address == '0);
    assign ring_write = avalon.write && (avalon.address != '0);
    assign flush      = csr_write && avalon.writedata[CSR_FLUSH];
    assign empty      = (count == '0);
    assign full       = (count == ptr_t'(RING_DEPTH));
    assign push       = ring_write && !full;
    assign word_len   = payload_len(word[7:0]);

    // A write to a full ring is held off until the FSM pops a word.
    assign avalon.waitrequest = ring_write && full;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        present    = 1'b0;
        advance    = 1'b0;
        pop        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable && !empty) begin
                    fetch      = 1'b1;
                    state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (word_len == 3'd0) begin
                    pop        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    present    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (consumed_event) begin
                    if (byte_idx < word_len) begin
                        advance    = 1'b1;
                        state_next = ST_PRESENT;
                    end else begin
                        pop        = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // Flush abandons whatever the FSM was about to do this cycle.
        if (flush) begin
            fetch      = 1'b0;
            present    = 1'b0;
            advance    = 1'b0;
            pop        = 1'b0;
            state_next = ST_IDLE;
        end
    end

    // NOTE: the ring storage has no reset; pointers and count define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clock) begin
        if (push && !reset) ring[wr_ptr] <= avalon.writedata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= ptr_t'(1);
            rd_ptr    <= ptr_t'(1);
            count     <= '0;
            enable    <= 1'b0;
            underrun  <= 1'b0;
            word      <= '0;
            byte_idx  <= 3'd0;
            tx_buffer <= IDLE_BYTE;
            tx_load   <= 1'b0;
        end else begin
            tx_load <= present;

            if (csr_write) enable <= avalon.writedata[CSR_ENABLE];

            if (csr_write && avalon.writedata[CSR_CLR_UNDERRUN])
                underrun <= 1'b0;
            else if (consumed_event && (state == ST_IDLE) && (empty || !enable))
                underrun <= 1'b1;

            if (flush) begin
                wr_ptr    <= ptr_t'(1);
                rd_ptr    <= ptr_t'(1);
                count     <= '0;
                tx_buffer <= IDLE_BYTE;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);

                if (push && !pop)      count <= count + ptr_t'(1);
                else if (pop && !push) count <= count - ptr_t'(1);

                if (fetch) begin
                    word     <= ring[rd_ptr];
                    byte_idx <= 3'd1;
                end else if (advance) begin
                    byte_idx <= byte_idx + 3'd1;
                end

                if (present)  tx_buffer <= word[{byte_idx, 3'b000} +: 8];
                else if (pop) tx_buffer <= IDLE_BYTE;
            end
        end
    end

    always_comb begin
        status                           = '0;
        status[STAT_WR_PTR +: ADDR_W]    = wr_ptr;
        status[STAT_RD_PTR +: ADDR_W]    = rd_ptr;
        status[STAT_COUNT +: ADDR_W]     = count;
        status[STAT_ENABLE]              = enable;
        status[STAT_UNDERRUN]            = underrun;
        status[STAT_EMPTY]               = empty;
        status[STAT_FULL]                = full;
        status[STAT_STATE +: 3]          = state;

        read_word = '0;
        if (avalon.read)
            read_word = (avalon.address == '0) ? status : ring[avalon.address];
    end

    assign avalon.readdata  = read_word;
    assign io_TX_Buffer     = tx_buffer;
    assign io_TX_BufferLoad = tx_load;
    assign io_TX_Underrun   = underrun;

endmodule

// File: tb/tb_spi_buffer_avalon_injector.sv
// Directed bench for the SPI stimulus injector: CSR/status, byte replay order,
// full-ring stall, underrun, flush, glitch filtering and tag clamping.
module tb_spi_buffer_avalon_injector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       consumed = 1'b0;
    logic [7:0] tx_buffer;
    logic       tx_load;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    logic        ld;
    logic [7:0]  b;
    logic [63:0] rd;

    spi_buffer_avalon_injector_if #(.ADDR_W(6), .DATA_W(64)) bus ();

    spi_buffer_avalon_injector #(
        .ADDR_W    (6),
        .DATA_W    (64),
        .IDLE_BYTE (8'hFF)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .avalon               (bus),
        .io_TX_Buffer         (tx_buffer),
        .io_TX_BufferLoad     (tx_load),
        .io_TX_BufferConsumed (consumed),
        .io_TX_Underrun       (underrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic csr_write(input logic [63:0] data);
        bus.address   = 6'd0;
        bus.writedata = data;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic push(input logic [5:0] addr, input logic [63:0] data);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] addr, output logic [63:0] data);
        bus.address = addr;
        bus.read    = 1'b1;
        #1;
        data        = bus.readdata;
        bus.read    = 1'b0;
    endtask

    // One clean consumed pulse; captures the buffer one cycle after the event edge.
    task automatic consume(output logic load_seen, output logic [7:0] byte_seen);
        consumed = 1'b1;
        tick();
        tick();
        consumed = 1'b0;
        tick();
        load_seen = tx_load;
        byte_seen = tx_buffer;
        tick();
    endtask

    initial begin
        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        bus_read(6'd0, rd);
        check("reset_status", rd, 64'h0000_0000_0400_0101);
        check("reset_tx", tx_buffer, 8'hFF);
        check("reset_load", tx_load, 1'b0);
        check("reset_wait", bus.waitrequest, 1'b0);

        // Seven-byte word replay and two-cycle latency
        csr_write(64'h1);
        push(6'd1, 64'h7766_5544_3322_1107);
        tick();
        check("lat_1cyc_tx", tx_buffer, 8'hFF);
        tick();
        check("byte1_tx", tx_buffer, 8'h11);
        check("byte1_load", tx_load, 1'b1);
        tick();
        check("load_one_cycle", tx_load, 1'b0);
        for (int k = 2; k <= 7; k++) begin
            consume(ld, b);
            check($sformatf("byte%0d_load", k), ld, 1'b1);
            check($sformatf("byte%0d_tx", k), b, 8'(k * 8'h11));
        end
        consume(ld, b);
        check("word_done_load", ld, 1'b0);
        check("word_done_tx", b, 8'hFF);
        bus_read(6'd0, rd);
        check("word_done_status", rd, 64'h0000_0000_0500_0202);

        // Reset mid-run, then two short words back to back
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_read(6'd0, rd);
        check("rerst_status", rd, 64'h0000_0000_0400_0101);
        csr_write(64'h1);
        push(6'd9, 64'h0000_0000_00BB_AA02);
        push(6'd3, 64'h0000_0000_0000_CC01);
        tick();
        check("aa_tx", tx_buffer, 8'hAA);
        check("aa_load", tx_load, 1'b1);
        consume(ld, b);
        check("bb_tx", b, 8'hBB);
        consume(ld, b);
        check("n2_pop_tx", b, 8'hFF);
        check("cc_tx", tx_buffer, 8'hCC);
        check("cc_load", tx_load, 1'b1);
        consume(ld, b);
        check("n1_pop_tx", b, 8'hFF);
        bus_read(6'd0, rd);
        check("short_words_status", rd, 64'h0000_0000_0500_0303);

        // Fill the ring while disabled
        csr_write(64'h2);
        for (int i = 1; i <= 63; i++)
            push(6'(i), 64'(i) << 8 | 64'h1);
        bus_read(6'd0, rd);
        check("full_status", rd, 64'h0000_0000_083F_0101);
        bus_read(6'd5, rd);
        check("ring_read5", rd, 64'h0000_0000_0000_0501);

        // 64th write stalls until a pop frees a slot
        csr_write(64'h1);
        tick();
        tick();
        check("full_first_byte", tx_buffer, 8'h01);
        bus.address   = 6'd7;
        bus.writedata = 64'hCAFE_F00D_0000_5A01;
        bus.write     = 1'b1;
        #1;
        check("stall_wait0", bus.waitrequest, 1'b1);
        consumed = 1'b1;
        tick();
        check("stall_wait1", bus.waitrequest, 1'b1);
        tick();
        check("stall_release", bus.waitrequest, 1'b0);
        tick();
        bus.write = 1'b0;
        consumed  = 1'b0;
        bus_read(6'd0, rd);
        check("after_stall_status", rd, 64'h0000_0000_193F_0202);
        bus_read(6'd1, rd);
        check("wrapped_slot1", rd, 64'hCAFE_F00D_0000_5A01);

        // Flush while presenting, disabled
        csr_write(64'h2);
        check("flush_tx", tx_buffer, 8'hFF);
        check("flush_load", tx_load, 1'b0);
        bus_read(6'd0, rd);
        check("flush_status", rd, 64'h0000_0000_0400_0101);

        // Underrun on an empty ring, then CSR clear
        tick();
        consume(ld, b);
        check("udr_load", ld, 1'b0);
        check("udr_tx", b, 8'hFF);
        check("udr_port", underrun, 1'b1);
        bus_read(6'd0, rd);
        check("udr_status", rd, 64'h0000_0000_0600_0101);
        csr_write(64'h4);
        check("udr_clear_port", underrun, 1'b0);

        // Flush mid-word after three bytes, keeping enable set
        csr_write(64'h1);
        push(6'd2, 64'h7766_5544_3322_1107);
        tick();
        tick();
        check("mid_b1", tx_buffer, 8'h11);
        tick();
        consume(ld, b);
        check("mid_b2", b, 8'h22);
        consume(ld, b);
        check("mid_b3", b, 8'h33);
        csr_write(64'h3);
        check("mid_flush_tx", tx_buffer, 8'hFF);
        bus_read(6'd0, rd);
        check("mid_flush_status", rd, 64'h0000_0000_0500_0101);
        consume(ld, b);
        check("mid_after_load", ld, 1'b0);
        check("mid_after_tx", b, 8'hFF);
        bus_read(6'd0, rd);
        check("mid_after_status", rd, 64'h0000_0000_0700_0101);

        // Single-cycle glitch is not an event
        csr_write(64'h5);
        consumed = 1'b1;
        tick();
        consumed = 1'b0;
        repeat (3) tick();
        check("glitch_underrun", underrun, 1'b0);
        bus_read(6'd0, rd);
        check("glitch_status", rd, 64'h0000_0000_0500_0101);

        // Zero-length word is popped without a Load pulse
        push(6'd3, 64'h0000_0000_0000_AB00);
        tick();
        tick();
        check("n0_load", tx_load, 1'b0);
        check("n0_tx", tx_buffer, 8'hFF);
        bus_read(6'd0, rd);
        check("n0_status", rd, 64'h0000_0000_0500_0202);

        // Tag above 7 clamps to seven payload bytes
        push(6'd4, 64'h0706_0504_0302_010F);
        tick();
        tick();
        check("clamp_b1", tx_buffer, 8'h01);
        tick();
        for (int k = 2; k <= 7; k++) begin
            consume(ld, b);
            check($sformatf("clamp_b%0d", k), b, 8'(k));
        end
        consume(ld, b);
        check("clamp_pop_load", ld, 1'b0);
        check("clamp_pop_tx", b, 8'hFF);
        bus_read(6'd0, rd);
        check("clamp_status", rd, 64'h0000_0000_0500_0303);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
